// File: rtl/exe_stage_pkg.sv
// Shared constants for the execute stage: command encodings and NZCV bit positions.
package exe_stage_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational execute ALU: computes the result and the next NZCV value.
// Subtraction is A + ~B + carry_in, so C reads as "no borrow".
module exe_alu
  import exe_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv_next
);

  logic             is_sub_s;
  logic             cin_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH:0]   sum_s;
  logic             add_v_s;
  logic             sub_v_s;
  logic [WIDTH-1:0] res_s;
  logic             c_s;
  logic             v_s;

  assign is_sub_s = (cmd == EXE_SUB) || (cmd == EXE_SBC);
  assign op_b_s   = is_sub_s ? ~b : b;
  assign sum_s    = {1'b0, a} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, cin_s};
  assign add_v_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  assign sub_v_s  = (a[WIDTH-1] != b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);

  // Carry-in selection for the shared adder
  always_comb begin
    cin_s = 1'b0;
    case (cmd)
      EXE_ADC: cin_s = c_in;
      EXE_SBC: cin_s = c_in;
      EXE_SUB: cin_s = 1'b1;
      default: cin_s = 1'b0;
    endcase
  end

  // Result and C/V selection; logical ops keep the incoming C and V
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = c_in;
    v_s   = v_in;
    case (cmd)
      EXE_ADD, EXE_ADC: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = add_v_s;
      end
      EXE_SUB, EXE_SBC: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = sub_v_s;
      end
      EXE_MOV: res_s = b;
      EXE_MVN: res_s = ~b;
      EXE_AND: res_s = a & b;
      EXE_ORR: res_s = a | b;
      EXE_EOR: res_s = a ^ b;
      EXE_NOP: res_s = {WIDTH{1'b0}};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  assign result    = res_s;
  assign nzcv_next = {res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), c_s, v_s};

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EX register, ALU, NZCV status register, branch resolution
// and EX/MEM register. Bubbles never touch status or assert memory/writeback.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [3:0]        exe_cmd,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic              wb_en,
  input  logic              b,
  input  logic              s,
  input  logic [WIDTH-1:0]  val_rn,
  input  logic [WIDTH-1:0]  val2,
  input  logic [WIDTH-1:0]  val_rm,
  input  logic [REG_AW-1:0] dest,
  input  logic [WIDTH-1:0]  pc,
  input  logic [23:0]       imm24,
  output logic              br_taken,
  output logic [WIDTH-1:0]  br_addr,
  output logic              out_valid,
  output logic [WIDTH-1:0]  alu_res,
  output logic [WIDTH-1:0]  st_val,
  output logic [REG_AW-1:0] dest_o,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o,
  output logic              wb_en_o,
  output logic [3:0]        status
);

  // ID/EX fields
  logic              valid_r;
  logic [3:0]        cmd_r;
  logic              mem_r_r;
  logic              mem_w_r;
  logic              wb_r;
  logic              b_r;
  logic              s_r;
  logic [WIDTH-1:0]  rn_r;
  logic [WIDTH-1:0]  val2_r;
  logic [WIDTH-1:0]  rm_r;
  logic [REG_AW-1:0] dest_r;
  logic [WIDTH-1:0]  pc_r;
  logic [23:0]       imm_r;

  // EX/MEM fields and status
  logic              out_valid_r;
  logic [WIDTH-1:0]  alu_res_r;
  logic [WIDTH-1:0]  st_val_r;
  logic [REG_AW-1:0] dest_o_r;
  logic              mem_r_o_r;
  logic              mem_w_o_r;
  logic              wb_o_r;
  logic [3:0]        status_r;

  logic [WIDTH-1:0]  alu_out_s;
  logic [3:0]        nzcv_s;
  logic [WIDTH-1:0]  br_off_s;
  logic              ctl_ok_s;

  exe_alu #(.WIDTH(WIDTH)) u_alu (
    .cmd       (cmd_r),
    .a         (rn_r),
    .b         (val2_r),
    .c_in      (status_r[ST_C]),
    .v_in      (status_r[ST_V]),
    .result    (alu_out_s),
    .nzcv_next (nzcv_s)
  );

  // Branch target: word offset from the sign-extended 24-bit immediate
  assign br_off_s = {{(WIDTH-26){imm_r[23]}}, imm_r, 2'b00};
  assign br_addr  = pc_r + br_off_s;
  assign br_taken = valid_r & b_r & ~hold;

  // Memory/writeback enables only pass for real, non-branch instructions
  assign ctl_ok_s = valid_r & ~b_r;

  // ID/EX register: flush beats hold, hold beats load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      cmd_r   <= 4'b0000;
      mem_r_r <= 1'b0;
      mem_w_r <= 1'b0;
      wb_r    <= 1'b0;
      b_r     <= 1'b0;
      s_r     <= 1'b0;
      rn_r    <= {WIDTH{1'b0}};
      val2_r  <= {WIDTH{1'b0}};
      rm_r    <= {WIDTH{1'b0}};
      dest_r  <= {REG_AW{1'b0}};
      pc_r    <= {WIDTH{1'b0}};
      imm_r   <= 24'h000000;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (hold) begin
      valid_r <= valid_r;
    end else begin
      valid_r <= in_valid;
      cmd_r   <= exe_cmd;
      mem_r_r <= mem_r_en;
      mem_w_r <= mem_w_en;
      wb_r    <= wb_en;
      b_r     <= b;
      s_r     <= s;
      rn_r    <= val_rn;
      val2_r  <= val2;
      rm_r    <= val_rm;
      dest_r  <= dest;
      pc_r    <= pc;
      imm_r   <= imm24;
    end
  end

  // EX/MEM register: captures the executed instruction unless frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      alu_res_r   <= {WIDTH{1'b0}};
      st_val_r    <= {WIDTH{1'b0}};
      dest_o_r    <= {REG_AW{1'b0}};
      mem_r_o_r   <= 1'b0;
      mem_w_o_r   <= 1'b0;
      wb_o_r      <= 1'b0;
    end else if (!hold) begin
      out_valid_r <= valid_r;
      alu_res_r   <= alu_out_s;
      st_val_r    <= rm_r;
      dest_o_r    <= dest_r;
      mem_r_o_r   <= mem_r_r & ctl_ok_s;
      mem_w_o_r   <= mem_w_r & ctl_ok_s;
      wb_o_r      <= wb_r & ctl_ok_s;
    end
  end

  // NZCV status: updated only by a valid, flag-setting instruction leaving EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_r <= 4'b0000;
    end else if (valid_r && s_r && !hold) begin
      status_r <= nzcv_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign alu_res    = alu_res_r;
  assign st_val     = st_val_r;
  assign dest_o     = dest_o_r;
  assign mem_r_en_o = mem_r_o_r;
  assign mem_w_en_o = mem_w_o_r;
  assign wb_en_o    = wb_o_r;
  assign status     = status_r;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a table of single-instruction vectors with
// chained status expectations, plus hand-written reset, carry, branch and hold sequences.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold, flush, in_valid;
  logic [3:0]  exe_cmd;
  logic        mem_r_en, mem_w_en, wb_en, b, s;
  logic [31:0] val_rn, val2, val_rm, pc;
  logic [3:0]  dest;
  logic [23:0] imm24;
  logic        br_taken, out_valid, mem_r_en_o, mem_w_en_o, wb_en_o;
  logic [31:0] br_addr, alu_res, st_val;
  logic [3:0]  dest_o, status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] bb;
    logic        s;
    logic [31:0] exp_res;
    logic [3:0]  exp_status;
  } vec_t;

  vec_t vecs[15];

  exe_stage #(.WIDTH(32), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .in_valid(in_valid),
    .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
    .b(b), .s(s), .val_rn(val_rn), .val2(val2), .val_rm(val_rm), .dest(dest),
    .pc(pc), .imm24(imm24), .br_taken(br_taken), .br_addr(br_addr),
    .out_valid(out_valid), .alu_res(alu_res), .st_val(st_val), .dest_o(dest_o),
    .mem_r_en_o(mem_r_en_o), .mem_w_en_o(mem_w_en_o), .wb_en_o(wb_en_o),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; exe_cmd = 4'b0000; mem_r_en = 1'b0; mem_w_en = 1'b0;
    wb_en = 1'b0; b = 1'b0; s = 1'b0; val_rn = 32'h0; val2 = 32'h0;
    val_rm = 32'h0; dest = 4'h0; pc = 32'h0; imm24 = 24'h0;
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic drive_alu(input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] bv, input logic sv);
    idle();
    in_valid = 1'b1; exe_cmd = c; val_rn = a; val2 = bv; s = sv;
    wb_en = 1'b1; dest = 4'h3;
  endtask

  initial begin
    vecs[0]  = '{"add_5_7",     4'b0010, 32'd5,         32'd7,         1'b1, 32'd12,        4'b0000};
    vecs[1]  = '{"sub_eq",      4'b0100, 32'd3,         32'd3,         1'b1, 32'd0,         4'b0110};
    vecs[2]  = '{"sub_0_1",     4'b0100, 32'd0,         32'd1,         1'b1, 32'hFFFFFFFF,  4'b1000};
    vecs[3]  = '{"add_ovf",     4'b0010, 32'h7FFFFFFF,  32'd1,         1'b1, 32'h80000000,  4'b1001};
    vecs[4]  = '{"and_keep_cv", 4'b0110, 32'hF0F0F0F0,  32'h0F0F0F0F,  1'b1, 32'd0,         4'b0101};
    vecs[5]  = '{"orr_s0",      4'b0111, 32'h80000000,  32'd1,         1'b0, 32'h80000001,  4'b0101};
    vecs[6]  = '{"mov",         4'b0001, 32'd0,         32'h80,        1'b1, 32'h80,        4'b0001};
    vecs[7]  = '{"mvn",         4'b1001, 32'd0,         32'd0,         1'b1, 32'hFFFFFFFF,  4'b1001};
    vecs[8]  = '{"eor",         4'b1000, 32'hFF,        32'hFF,        1'b1, 32'd0,         4'b0101};
    vecs[9]  = '{"add_carry",   4'b0010, 32'hFFFFFFFF,  32'd1,         1'b1, 32'd0,         4'b0110};
    vecs[10] = '{"sub_1_2",     4'b0100, 32'd1,         32'd2,         1'b1, 32'hFFFFFFFF,  4'b1000};
    vecs[11] = '{"sbc_c0",      4'b0101, 32'd5,         32'd3,         1'b1, 32'd1,         4'b0010};
    vecs[12] = '{"adc_c1",      4'b0011, 32'd1,         32'd1,         1'b1, 32'd3,         4'b0000};
    vecs[13] = '{"sub_ovf",     4'b0100, 32'h80000000,  32'd1,         1'b1, 32'h7FFFFFFF,  4'b0011};
    vecs[14] = '{"cmd_other",   4'b1111, 32'h1234,      32'h5678,      1'b1, 32'd0,         4'b0111};

    // Reset state
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_status",    {28'd0, status},    32'd0);
    chk("rst_br_taken",  {31'd0, br_taken},  32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-traffic: flag-setting ADD then a branch, reset asserted mid-cycle
    @(negedge clk);
    drive_alu(4'b0010, 32'h7FFFFFFF, 32'd1, 1'b1);
    @(negedge clk);
    idle();
    in_valid = 1'b1; b = 1'b1; pc = 32'h200; imm24 = 24'h000001;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_status",    {28'd0, status},    32'h9);
    chk("pre_rst_br_taken",  {31'd0, br_taken},  32'd1);
    rst = 1'b0;
    idle();
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid},  32'd0);
    chk("async_rst_alu_res",   alu_res,             32'd0);
    chk("async_rst_wb",        {31'd0, wb_en_o},    32'd0);
    chk("async_rst_status",    {28'd0, status},     32'd0);
    chk("async_rst_br_taken",  {31'd0, br_taken},   32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table of single instructions; status expectations chain through the table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_alu(vecs[i].cmd, vecs[i].a, vecs[i].bb, vecs[i].s);
      @(negedge clk);
      idle();
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_res"},    alu_res,               vecs[i].exp_res);
      chk({vecs[i].name, "_status"}, {28'd0, status},       {28'd0, vecs[i].exp_status});
      chk({vecs[i].name, "_valid"},  {31'd0, out_valid},    32'd1);
      chk({vecs[i].name, "_wb"},     {31'd0, wb_en_o},      32'd1);
    end

    // Carry chain: back-to-back ADD then ADC sees the new carry without a bubble
    @(negedge clk);
    drive_alu(4'b0010, 32'hFFFFFFFF, 32'd1, 1'b1);
    @(negedge clk);
    drive_alu(4'b0011, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk("chain_add_res",    alu_res,         32'd0);
    chk("chain_add_status", {28'd0, status}, 32'h6);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("chain_adc_res",    alu_res,         32'd1);
    chk("chain_adc_status", {28'd0, status}, 32'h0);

    // Branch with flush of the following instruction
    @(negedge clk);
    drive_alu(4'b0010, 32'd1, 32'd1, 1'b0);
    b = 1'b1; pc = 32'h100; imm24 = 24'hFFFFFE;
    @(posedge clk);
    #1;
    chk("br_taken", {31'd0, br_taken}, 32'd1);
    chk("br_addr",  br_addr,           32'hF8);
    @(negedge clk);
    drive_alu(4'b0010, 32'd2, 32'd2, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("br_exmem_valid", {31'd0, out_valid}, 32'd1);
    chk("br_exmem_wb",    {31'd0, wb_en_o},   32'd0);
    chk("br_after_flush", {31'd0, br_taken},  32'd0);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("flushed_valid", {31'd0, out_valid}, 32'd0);
    chk("flushed_wb",    {31'd0, wb_en_o},   32'd0);

    // Hold: STR sits in EX for three frozen cycles, then emerges exactly once
    @(negedge clk);
    idle();
    in_valid = 1'b1; exe_cmd = 4'b0010; val_rn = 32'h7FFFFFFF; val2 = 32'd1;
    val_rm = 32'hDEADBEEF; mem_w_en = 1'b1; s = 1'b1; dest = 4'h9;
    @(negedge clk);
    idle();
    hold = 1'b1; in_valid = 1'b1; exe_cmd = 4'b0001; val2 = 32'h55; mem_r_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid",  {31'd0, out_valid},  32'd0);
      chk("hold_memw",   {31'd0, mem_w_en_o}, 32'd0);
      chk("hold_status", {28'd0, status},     32'd0);
    end
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    chk("str_valid",  {31'd0, out_valid},  32'd1);
    chk("str_memw",   {31'd0, mem_w_en_o}, 32'd1);
    chk("str_memr",   {31'd0, mem_r_en_o}, 32'd0);
    chk("str_stval",  st_val,              32'hDEADBEEF);
    chk("str_addr",   alu_res,             32'h80000000);
    chk("str_dest",   {28'd0, dest_o},     32'h9);
    chk("str_status", {28'd0, status},     32'h9);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("str_once_valid", {31'd0, out_valid},  32'd0);
    chk("str_once_memw",  {31'd0, mem_w_en_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute-stage consumer of the control bundle produced by the decode-side control unit.
- Registers the decoded instruction (ID/EX), executes exe_cmd on the operands, and maintains the NZCV status register.
- Resolves branches and registers results plus memory/writeback controls into EX/MEM for the memory stage.
- Two registered stages; supports hold (pipeline freeze) and flush (bubble insert).

Parameters:
WIDTH, 32, datapath width
REG_AW, 4, register-file address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
hold  in  1  freeze every register, including status
flush  in  1  load a bubble into ID/EX
in_valid  in  1  decode slot holds a real instruction
exe_cmd  in  4  execute command from decode
mem_r_en  in  1  load
mem_w_en  in  1  store
wb_en  in  1  register writeback
b  in  1  branch
s  in  1  update status (s_out from control unit)
val_rn  in  WIDTH  first operand
val2  in  WIDTH  second operand (shifted/immediate)
val_rm  in  WIDTH  store data
dest  in  REG_AW  destination register
pc  in  WIDTH  PC+4 of instruction
imm24  in  24  branch offset
br_taken  out  1  branch resolved taken (combinational from ID/EX)
br_addr  out  WIDTH  branch target
out_valid  out  1  EX/MEM valid
alu_res  out  WIDTH  registered result / memory address
st_val  out  WIDTH  registered store data
dest_o  out  REG_AW  registered destination
mem_r_en_o, mem_w_en_o, wb_en_o  out  1 each  registered controls, gated by valid
status  out  4  NZCV register {N,Z,C,V}

Behaviour:
- Reset (rst=0, async): every ID/EX and EX/MEM field = 0, status = 0. Outputs therefore 0: out_valid, controls, br_taken.
- Latency: inputs captured at edge k; alu_res, controls and status visible after edge k+1. br_taken/br_addr are valid during the cycle between edges k and k+1.
- ID/EX update per edge:
  - flush=1: valid <= 0, even under hold.
  - else hold=1: keep.
  - else: load all inputs, with valid <= in_valid.
- EX/MEM update per edge:
  - hold=1: keep.
  - else: load ALU result, val_rm, dest, and controls ANDed with ID/EX valid; out_valid <= valid.
- exe_cmd semantics (A=val_rn, B=val2):
  - 0001 MOV B; 1001 MVN ~B
  - 0010 ADD A+B; 0011 ADC A+B+C
  - 0100 SUB A-B; 0101 SBC A-B-!C
  - 0110 AND; 0111 ORR; 1000 EOR
  - 0000 and others: result 0
  - Arithmetic is WIDTH+1 bits; C = bit WIDTH.
  - Subtract carry means no-borrow: A-B computed as A+~B+1.
- Flags:
  - N = res[WIDTH-1]; Z = (res==0).
  - ADD/ADC: V = (A,B same sign) & (res sign differs).
  - SUB/SBC: V = (A,B sign differs) & (res sign != A sign).
  - Logical/MOV/MVN: C and V preserved.
- Status register updates at the edge leaving EX only when ID/EX valid & s & !hold. ADC/SBC read the current register, so the next instruction sees updated flags with no bubble.
- Branch: br_taken = ID/EX valid & b & !hold. br_addr = pc + (sign_extend(imm24) << 2), mod 2^WIDTH. A branch instruction has wb/mem controls forced 0 in EX/MEM.
- Control coupling: the stage does not drive flush itself; the top level feeds br_taken back to flush.
- Invalid entries (bubbles) never change status or assert any memory or writeback enable.
- Wrap-around: adds and subtracts wrap modulo 2^WIDTH; carry and overflow are reported only via flags.
- Reset mid-operation: both stages and status are cleared immediately and asynchronously; no partial writeback.

Decomposition:
- Shared package holds:
  - EXE_* command constants (MOV=4'b0001 ... EOR=4'b1000, NOP=4'b0000);
  - status bit index constants N=3, Z=2, C=1, V=0.
- One sub-module exe_alu: purely combinational; inputs (cmd, A, B, C_in); outputs result and NZCV_next.
- Pipeline registers, status register and branch adder stay in exe_stage.

Test Plan:
- Reset: drive rst=0 mid-traffic -> all outputs 0 and status 4'b0000 immediately. Release, then ADD 5+7 s=1 -> alu_res=12 two edges later, status=0000.
- Flags: SUB 3-3 s=1 -> res 0, status=0110 (Z,C). Then SUB 0-1 s=1 -> res 0xFFFFFFFF, status=1000.
- Carry chain: ADD 0xFFFFFFFF+1 s=1, back-to-back ADC 0+0 -> first res 0, status=0110; second res 1.
- Overflow and gating: ADD 0x7FFFFFFF+1 s=1 -> status=1001. Follow with AND s=1 -> C and V bits unchanged. With s=0, status unchanged.
- Branch: b=1, pc=0x100, imm24=0xFFFFFE -> br_taken=1, br_addr=0xF8. Same cycle flush=1 -> next instruction's out_valid=0, wb_en_o=0.
- Hold: hold=1 for 3 cycles with a STR in EX -> outputs, status and ID/EX frozen. On release the STR emerges once with mem_w_en_o=1, st_val=val_rm.
